// File: rtl/dram_bus_arbiter.sv
// dram_bus_arbiter
//   Hands the shared DRAM bus to one owner at a time: four DMA channels
//   (round-robin), the CPU path, internal refresh cycles and, when built with
//   DRAM_EXT_MASTER_EN, an external bus master. Exactly one grant is active at
//   a time. A granted cycle is closed by the bus interface's bus_done pulse.
//
// Build option:
//   DRAM_EXT_MASTER_EN  defined  -> EXT state present; ext_bus_req honoured.
//                       undefined -> ext_bus_req ignored, ext_bus_grant = 0,
//                                    dram_bus_en = 1.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   drq[3:0]        DMA requests (level, already synchronized)
//   dram_n_dack     active-low DMA acknowledges (= ~dma_grant)
//   dma_grant       one-hot DMA grant
//   cpu_req/lock    CPU request; lock keeps the bus across bus_done
//   cpu_grant       CPU owns the bus
//   refresh_grant   bus interface runs one refresh cycle
//   bus_done        one-cycle pulse, current granted cycle finished
//   ext_bus_req     external master requests the bus
//   ext_bus_grant   bus released to the external master
//   dram_bus_en     1 = this chip drives the DRAM pins
module dram_bus_arbiter #(
    parameter int REFRESH_DIVIDER = 128,
    parameter int REFRESH_PEND_W  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] drq,
    output logic [3:0] dram_n_dack,
    output logic [3:0] dma_grant,
    input  logic       cpu_req,
    input  logic       cpu_lock,
    output logic       cpu_grant,
    output logic       refresh_grant,
    input  logic       bus_done,
    input  logic       ext_bus_req,
    output logic       ext_bus_grant,
    output logic       dram_bus_en
);

    localparam int CNT_W = $clog2(REFRESH_DIVIDER);
    localparam logic [CNT_W-1:0]          CNT_RELOAD = CNT_W'(REFRESH_DIVIDER - 1);
    localparam logic [REFRESH_PEND_W-1:0] PEND_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1
`ifdef DRAM_EXT_MASTER_EN
        ,
        EXT  = 2'd2
`endif
    } state_t;

    state_t                    state_q, state_d;
    logic [3:0]                dma_q, dma_d;
    logic                      cpu_q, cpu_d;
    logic                      ref_q, ref_d;
    logic [1:0]                rr_q, rr_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [REFRESH_PEND_W-1:0] pend_q, pend_d;
    logic                      pend_inc, pend_dec;
    logic                      found;
    logic [1:0]                pick;
`ifdef DRAM_EXT_MASTER_EN
    logic                      ext_q, ext_d;
`else
    logic                      unused_ext_req;
    assign unused_ext_req = ext_bus_req;
`endif

    // Refresh timer runs in every state; pending requests accumulate while
    // the bus is busy so no refresh is lost (up to saturation).
    always_comb begin
        pend_inc = (cnt_q == '0);
        cnt_d    = pend_inc ? CNT_RELOAD : cnt_q - 1'b1;
        pend_d   = pend_q;
        if (pend_inc && !pend_dec && pend_q != PEND_MAX)
            pend_d = pend_q + 1'b1;
        else if (pend_dec && !pend_inc)
            pend_d = pend_q - 1'b1;
    end

    // Round-robin search starting at rr_q.
    always_comb begin
        found = 1'b0;
        pick  = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!found && drq[rr_q + 2'(i)]) begin
                found = 1'b1;
                pick  = rr_q + 2'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        dma_d    = dma_q;
        cpu_d    = cpu_q;
        ref_d    = ref_q;
        rr_d     = rr_q;
        pend_dec = 1'b0;
`ifdef DRAM_EXT_MASTER_EN
        ext_d    = ext_q;
`endif
        case (state_q)
            IDLE: begin
                if (pend_q != '0) begin
                    state_d  = OWN;
                    ref_d    = 1'b1;
                    pend_dec = 1'b1;
                end
`ifdef DRAM_EXT_MASTER_EN
                else if (ext_bus_req) begin
                    state_d = EXT;
                    ext_d   = 1'b1;
                end
`endif
                else if (found) begin
                    state_d = OWN;
                    dma_d   = 4'b0001 << pick;
                    rr_d    = pick + 2'd1;
                end else if (cpu_req) begin
                    state_d = OWN;
                    cpu_d   = 1'b1;
                end
            end
            OWN: begin
                // A locked CPU burst keeps the bus across bus_done.
                if (bus_done && !(cpu_q && cpu_lock)) begin
                    state_d = IDLE;
                    dma_d   = '0;
                    cpu_d   = 1'b0;
                    ref_d   = 1'b0;
                end
            end
`ifdef DRAM_EXT_MASTER_EN
            EXT: begin
                if (!ext_bus_req) begin
                    state_d = IDLE;
                    ext_d   = 1'b0;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                dma_d   = '0;
                cpu_d   = 1'b0;
                ref_d   = 1'b0;
`ifdef DRAM_EXT_MASTER_EN
                ext_d   = 1'b0;
`endif
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            dma_q   <= '0;
            cpu_q   <= 1'b0;
            ref_q   <= 1'b0;
            rr_q    <= 2'd0;
            cnt_q   <= CNT_RELOAD;
            pend_q  <= '0;
`ifdef DRAM_EXT_MASTER_EN
            ext_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            dma_q   <= dma_d;
            cpu_q   <= cpu_d;
            ref_q   <= ref_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
`ifdef DRAM_EXT_MASTER_EN
            ext_q   <= ext_d;
`endif
        end
    end

    assign dma_grant     = dma_q;
    assign dram_n_dack   = ~dma_q;
    assign cpu_grant     = cpu_q;
    assign refresh_grant = ref_q;
`ifdef DRAM_EXT_MASTER_EN
    assign ext_bus_grant = ext_q;
    assign dram_bus_en   = ~ext_q;
`else
    assign ext_bus_grant = 1'b0;
    assign dram_bus_en   = 1'b1;
`endif

endmodule

// File: doc/dram_bus_arbiter.md
# dram_bus_arbiter

Sequences ownership of the shared DRAM bus between four DMA channels (`drq[3:0]`), the CPU memory path, internally generated refresh cycles and, optionally, an external bus master. Sits between the requesters and the DRAM bus interface. Issues exactly one one-hot grant at a time, drives the active-low DMA acknowledges and produces the bus-enable used for tri-stating the DRAM pins. The granted bus cycle is closed by the bus interface's `bus_done` pulse.

## Interface
- `REFRESH_DIVIDER`, 128: clock cycles between refresh requests (≥2)
- `REFRESH_PEND_W`, 3: width of the saturating pending-refresh counter
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-high
- `drq`  in  4  DMA requests; level, pre-synchronized
- `dram_n_dack`  out  4  DMA acknowledge, active-low, = ~`dma_grant`
- `dma_grant`  out  4  one-hot DMA channel grant
- `cpu_req`  in  1  CPU requests bus
- `cpu_lock`  in  1  CPU holds bus across `bus_done` (burst)
- `cpu_grant`  out  1  CPU owns bus
- `refresh_grant`  out  1  bus interface must run one refresh cycle
- `bus_done`  in  1  single-cycle pulse: current granted cycle complete
- `ext_bus_req`  in  1  external master requests bus
- `ext_bus_grant`  out  1  bus released to external master
- `dram_bus_en`  out  1  1 = this chip drives DRAM pins

## Operation
- States: IDLE, OWN (one grant active), EXT (bus released).
- Priority evaluated in IDLE only: refresh pending > `ext_bus_req` > DMA (round-robin) > CPU.
- Refresh: down-counter loads `REFRESH_DIVIDER-1`, decrements every cycle in all states; at 0 reloads and increments pending count, saturating at 2^`REFRESH_PEND_W`-1. Entering OWN on refresh decrements pending. Same-cycle increment and decrement: count unchanged.
- DMA round-robin: pointer `rr` (2 bits); search `rr`, `rr+1`, … mod 4 for first set `drq`; on grant of channel k, `rr` ← k+1 mod 4.
- IDLE→OWN: chosen grant registered. OWN→IDLE on `bus_done`, except CPU owner with `cpu_lock`=1 stays in OWN. `bus_done` in IDLE/EXT ignored.
- Grant is held to `bus_done` regardless of `drq`/`cpu_req` dropping.
- IDLE→EXT on `ext_bus_req`; EXT→IDLE when `ext_bus_req`=0. In EXT: `dram_bus_en`=0, `ext_bus_grant`=1, no other grants.
- Invariant: at most one of `dma_grant[*]`, `cpu_grant`, `refresh_grant`, `ext_bus_grant` is 1.

## Timing
- Reset values: all grants 0, `dram_n_dack`=4'hF, `ext_bus_grant`=0, `dram_bus_en`=1, state IDLE, `rr`=0, pending 0, counter `REFRESH_DIVIDER-1`.
- All outputs registered.
- Request sampled in IDLE at edge N → grant high after edge N.
- `bus_done` sampled at edge M → grant low after edge M; state IDLE for ≥1 cycle; next grant earliest after edge M+1 (one-cycle turnaround between owners).
- First refresh pending `REFRESH_DIVIDER` cycles after reset release.
- EXT exit: `dram_bus_en`=1 and `ext_bus_grant`=0 after the edge sampling `ext_bus_req`=0.
- Reset asserted mid-grant: all outputs return to reset values immediately (asynchronous); in-flight cycle abandoned.

## Configuration
- `DRAM_EXT_MASTER_EN` defined: EXT state and external-master behaviour as above.
- Not defined: `ext_bus_req` ignored, EXT state absent, `ext_bus_grant` constant 0, `dram_bus_en` constant 1; ports remain.

## Test plan
- Reset, `REFRESH_DIVIDER`=16, no requests → `refresh_grant` high after cycle 16; `bus_done` pulse → low next cycle; repeats every 16 cycles.
- `drq`=4'b1111 held, `bus_done` one cycle after each grant → grants ch0,1,2,3,0 in order; `dram_n_dack` = 4'b1110, 1101, 1011, 0111, with one all-high idle cycle between each.
- `cpu_req`=1, `cpu_lock`=1, three `bus_done` pulses, then `cpu_lock`=0 + `bus_done` → `cpu_grant` continuous through the first three, low after the fourth; `drq[2]` raised mid-burst → `dma_grant`=4'b0100 after the one-cycle turnaround.
- Bus held 40 cycles by CPU lock with `REFRESH_DIVIDER`=16 → pending=2; after release two consecutive refresh grants precede the waiting DMA request.
- `DRAM_EXT_MASTER_EN` defined, `ext_bus_req`=1 while CPU owns bus → external grant waits for `bus_done`; then `dram_bus_en`=0, `ext_bus_grant`=1; drop req → `dram_bus_en`=1 next edge. Without the macro → `dram_bus_en` stays 1.
- `rst` pulsed while `dma_grant`=4'b0010 → `dram_n_dack`=4'hF immediately, `rr`=0, refresh counter reloaded.
